// File: rtl/mem_pkg.sv
// Shared definitions for the memory request controller: geometry defaults and FSM state encoding.
package mem_pkg;

  localparam int MEM_DEPTH = 128;
  localparam int MEM_AW    = $clog2(MEM_DEPTH);
  localparam int MEM_DW    = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } mem_state_e;

endpackage

// File: rtl/mem_req_ctrl_stats.sv
// Saturating write/read activity counters; only built when MEM_REQ_CTRL_STATS_EN is defined.
module mem_req_ctrl_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_inc,
  input  logic        rd_inc,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt
);

  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (wr_inc && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
    if (rd_inc && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;

endmodule

// File: rtl/mem_req_ctrl.sv
// Initiator-side controller for the single-port memory: single writes, sequential read bursts.
// Optional activity counters are enabled by defining MEM_REQ_CTRL_STATS_EN.
//
// state | meaning
// IDLE  | ready for a request
// WRITE | write cycle on the memory pins
// READ  | read sample cycle on the memory pins
// WAIT  | memory read latency countdown
// RESP  | read word offered to the consumer
module mem_req_ctrl
  import mem_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int AW     = MEM_AW,
  parameter int DW     = MEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [3:0]    req_len,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_last,
  output logic          mem_cs,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data
`ifdef MEM_REQ_CTRL_STATS_EN
  ,
  output logic [15:0]   stat_wr_cnt,
  output logic [15:0]   stat_rd_cnt
`endif
);

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  mem_state_e    state_q, state_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    beat_q, beat_d;
  logic [1:0]    lat_q, lat_d;
  logic          mem_cs_q, mem_cs_d;
  logic          mem_wr_q, mem_wr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wr_data_q, mem_wr_data_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_last_q, rsp_last_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

  assign req_ready = (state_q == ST_IDLE) && !rst;

  // Pin values are computed for the state being entered so they appear registered in that state.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    beat_d        = beat_q;
    lat_d         = lat_q;
    mem_cs_d      = 1'b0;
    mem_wr_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_last_d    = rsp_last_q;
    rsp_rdata_d   = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          len_d      = req_len;
          mem_cs_d   = 1'b1;
          mem_addr_d = req_addr;
          if (req_wr) begin
            mem_wr_d      = 1'b1;
            mem_wr_data_d = req_wdata;
            state_d       = ST_WRITE;
          end else begin
            beat_d  = '0;
            state_d = ST_READ;
          end
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ: begin
        lat_d   = LAT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_q == 2'd0) begin
          rsp_rdata_d = mem_rd_data;
          rsp_valid_d = 1'b1;
          rsp_last_d  = (beat_q == len_q);
          state_d     = ST_RESP;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          if (rsp_last_q) begin
            state_d = ST_IDLE;
          end else begin
            mem_addr_d = mem_addr_q + 1'b1;
            beat_d     = beat_q + 4'd1;
            mem_cs_d   = 1'b1;
            state_d    = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      beat_q        <= '0;
      lat_q         <= '0;
      mem_cs_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_last_q    <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      lat_q         <= lat_d;
      mem_cs_q      <= mem_cs_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_last_q    <= rsp_last_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  assign mem_cs      = mem_cs_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_last    = rsp_last_q;
  assign rsp_rdata   = rsp_rdata_q;

`ifdef MEM_REQ_CTRL_STATS_EN
  mem_req_ctrl_stats u_stats (
    .clk    (clk),
    .rst    (rst),
    .wr_inc (state_q == ST_WRITE),
    .rd_inc ((state_q == ST_RESP) && rsp_ready),
    .wr_cnt (stat_wr_cnt),
    .rd_cnt (stat_rd_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: an RD_LAT=1 instance and an RD_LAT=4 instance, each with a memory model.
module tb_mem_req_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_wr, rsp_valid, rsp_ready, rsp_last, mem_cs, mem_wr;
  logic [6:0]  req_addr, mem_addr;
  logic [31:0] req_wdata, rsp_rdata, mem_wr_data, mem_rd_data;
  logic [3:0]  req_len;

  logic        b_req_valid, b_req_ready, b_req_wr, b_rsp_valid, b_rsp_ready, b_rsp_last, b_mem_cs, b_mem_wr;
  logic [6:0]  b_req_addr, b_mem_addr;
  logic [31:0] b_req_wdata, b_rsp_rdata, b_mem_wr_data, b_mem_rd_data;
  logic [3:0]  b_req_len;

`ifdef MEM_REQ_CTRL_STATS_EN
  logic [15:0] stat_wr, stat_rd, b_stat_wr, b_stat_rd;
`endif

  mem_req_ctrl #(.RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last), .mem_cs(mem_cs),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
`ifdef MEM_REQ_CTRL_STATS_EN
    , .stat_wr_cnt(stat_wr), .stat_rd_cnt(stat_rd)
`endif
  );

  mem_req_ctrl #(.RD_LAT(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_len(b_req_len), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_last(b_rsp_last), .mem_cs(b_mem_cs),
    .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wr_data(b_mem_wr_data), .mem_rd_data(b_mem_rd_data)
`ifdef MEM_REQ_CTRL_STATS_EN
    , .stat_wr_cnt(b_stat_wr), .stat_rd_cnt(b_stat_rd)
`endif
  );

  logic [31:0] mem1 [128];
  logic [31:0] mem4 [128];
  logic [31:0] rd4  [4];
  logic [31:0] ref_mem [128];
  int wr_pulses = 0;

  always @(posedge clk) begin
    if (mem_cs && mem_wr) begin
      mem1[mem_addr] <= mem_wr_data;
      wr_pulses <= wr_pulses + 1;
    end
    if (mem_cs && !mem_wr) mem_rd_data <= mem1[mem_addr];
  end

  always @(posedge clk) begin
    if (b_mem_cs && b_mem_wr) mem4[b_mem_addr] <= b_mem_wr_data;
    if (b_mem_cs && !b_mem_wr) rd4[0] <= mem4[b_mem_addr];
    for (int i = 1; i < 4; i++) rd4[i] <= rd4[i-1];
  end
  assign b_mem_rd_data = rd4[3];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic write1(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    check("wr_idle_cs", 32'(mem_cs), 32'd0);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_len = 4'hF;
    #1 check("wr_rdy_in", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_wr = 1'b0;
    check("wr_cs", 32'(mem_cs), 32'd1);
    check("wr_we", 32'(mem_wr), 32'd1);
    check("wr_addr", 32'(mem_addr), 32'(a));
    check("wr_data", mem_wr_data, d);
    check("wr_rdy_busy", 32'(req_ready), 32'd0);
    ref_mem[a] = d;
  endtask

  task automatic read_burst(input logic [6:0] a, input logic [3:0] len, input int hold);
    logic [6:0] ea;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a; req_len = len; req_wdata = '0;
    #1 check("rd_rdy_in", 32'(req_ready), 32'd1);
    ea = a;
    for (int b = 0; b <= int'(len); b++) begin
      @(negedge clk);
      req_valid = 1'b0;
      check("rd_cs", 32'(mem_cs), 32'd1);
      check("rd_we0", 32'(mem_wr), 32'd0);
      check("rd_addr", 32'(mem_addr), 32'(ea));
      @(negedge clk);
      check("wait_cs", 32'(mem_cs), 32'd0);
      check("wait_vld", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("rsp_vld", 32'(rsp_valid), 32'd1);
      check("rsp_data", rsp_rdata, ref_mem[ea]);
      check("rsp_last", 32'(rsp_last), 32'(b == int'(len)));
      if (b == 0 && hold > 0) begin
        rsp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          check("hold_vld", 32'(rsp_valid), 32'd1);
          check("hold_data", rsp_rdata, ref_mem[ea]);
          check("hold_cs", 32'(mem_cs), 32'd0);
        end
        rsp_ready = 1'b1;
      end
      ea = ea + 7'd1;
    end
    @(negedge clk);
    check("rd_done_rdy", 32'(req_ready), 32'd1);
    check("rd_done_vld", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_len = '0; rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_len = '0; b_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rdy", 32'(req_ready), 32'd0);
    check("rst_cs", 32'(mem_cs), 32'd0);
    check("rst_we", 32'(mem_wr), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wr_data, 32'd0);
    check("rst_vld", 32'(rsp_valid), 32'd0);
    check("rst_last", 32'(rsp_last), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    #1 check("rst_rel_rdy", 32'(req_ready), 32'd1);

    write1(7'd29, 32'd29);
    write1(7'd27, 32'd27);
    write1(7'd28, 32'd30);
    write1(7'd19, 32'd15);
    write1(7'd126, 32'h1111_007E);
    write1(7'd127, 32'h2222_007F);
    write1(7'd0,   32'h3333_0000);
    write1(7'd1,   32'h4444_0001);
    @(negedge clk);
    check("wr_pulses", 32'(wr_pulses), 32'd8);

    read_burst(7'd27, 4'd0, 0);
    read_burst(7'd28, 4'd0, 0);
    read_burst(7'd126, 4'd3, 0);
    read_burst(7'd27, 4'd1, 5);

`ifdef MEM_REQ_CTRL_STATS_EN
    check("stat_wr", 32'(stat_wr), 32'd8);
    check("stat_rd", 32'(stat_rd), 32'd8);
`endif

    // Reset during WAIT of a three-beat burst
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 7'd27; req_len = 4'd2;
    @(negedge clk);
    req_valid = 1'b0;
    check("rr_read_cs", 32'(mem_cs), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rr_vld", 32'(rsp_valid), 32'd0);
    check("rr_cs", 32'(mem_cs), 32'd0);
    check("rr_rdy_in_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_post_rdy", 32'(req_ready), 32'd1);
      check("rr_post_vld", 32'(rsp_valid), 32'd0);
      check("rr_post_cs", 32'(mem_cs), 32'd0);
    end

    // RD_LAT=4 instance: three writes then a two-beat read
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b_req_valid = 1'b1; b_req_wr = 1'b1; b_req_addr = 7'(5 + i); b_req_wdata = 32'(32'h55 + 17 * i);
      #1 check("b_wr_rdy", 32'(b_req_ready), 32'd1);
      @(negedge clk);
      b_req_valid = 1'b0; b_req_wr = 1'b0;
      check("b_wr_cs", 32'(b_mem_cs & b_mem_wr), 32'd1);
      check("b_wr_addr", 32'(b_mem_addr), 32'(5 + i));
    end
    @(negedge clk);
    b_req_valid = 1'b1; b_req_wr = 1'b0; b_req_addr = 7'd5; b_req_len = 4'd1;
    #1 check("b_rd_rdy", 32'(b_req_ready), 32'd1);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      b_req_valid = 1'b0;
      check("b_rd_cs", 32'(b_mem_cs), 32'd1);
      check("b_rd_addr", 32'(b_mem_addr), 32'(5 + b));
      for (int w = 0; w < 4; w++) begin
        @(negedge clk);
        check("b_wait_vld", 32'(b_rsp_valid), 32'd0);
      end
      @(negedge clk);
      check("b_rsp_vld", 32'(b_rsp_valid), 32'd1);
      check("b_rsp_data", b_rsp_rdata, (b == 0) ? 32'h55 : 32'h66);
      check("b_rsp_last", 32'(b_rsp_last), 32'(b == 1));
    end
    @(negedge clk);
    check("b_done_rdy", 32'(b_req_ready), 32'd1);
`ifdef MEM_REQ_CTRL_STATS_EN
    check("b_stat_wr", 32'(b_stat_wr), 32'd3);
    check("b_stat_rd", 32'(b_stat_rd), 32'd2);
    check("stat_wr_rst", 32'(stat_wr), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
